// File: rtl/pe_cluster_psum_acc_if.sv
// ---------------------------------------------------------------------------
// pe_cluster_psum_acc_if
//
// Bundles the row-side partial-sum inputs and the output valid/ready stream of
// the PE cluster psum accumulator.
//
// Signals:
//   i_peout_data   MAX_ROW_NUM x DATA_WIDTH  per-row partial sum
//   i_peout_valid  MAX_ROW_NUM               per-row partial sum pulse
//   o_data         DATA_WIDTH                completed sum at FIFO head
//   o_row_idx      LOG_MRN                   originating row of o_data
//   o_valid        1                         FIFO non-empty
//   i_ready        1                         consumer accepts the head entry
//
// Modports:
//   master  the accumulator (drives o_*, consumes i_*)
//   slave   the surrounding environment (drives i_*, consumes o_*)
// ---------------------------------------------------------------------------
interface pe_cluster_psum_acc_if #(
  parameter int DATA_WIDTH  = 16,
  parameter int MAX_ROW_NUM = 16
);

  localparam int LOG_MRN = $clog2(MAX_ROW_NUM);

  logic [MAX_ROW_NUM-1:0][DATA_WIDTH-1:0] i_peout_data;
  logic [MAX_ROW_NUM-1:0]                 i_peout_valid;
  logic [DATA_WIDTH-1:0]                  o_data;
  logic [LOG_MRN-1:0]                     o_row_idx;
  logic                                   o_valid;
  logic                                   i_ready;

  modport master (
    input  i_peout_data,
    input  i_peout_valid,
    input  i_ready,
    output o_data,
    output o_row_idx,
    output o_valid
  );

  modport slave (
    output i_peout_data,
    output i_peout_valid,
    output i_ready,
    input  o_data,
    input  o_row_idx,
    input  o_valid
  );

endinterface

// File: rtl/pe_cluster_psum_acc.sv
// ---------------------------------------------------------------------------
// pe_cluster_psum_acc
//
// Output stage of the PE cluster. Each enabled PE row delivers partial sums as
// single-cycle pulses; every row accumulates its own pulses with saturating
// signed arithmetic over a programmable number of channels. A completed row
// sum waits in a per-row holding register until a fixed-priority arbiter
// (lowest row index first) moves it into a shared output FIFO, which drains
// through a valid/ready handshake.
//
// Ports:
//   clk            in   single clock, rising edge
//   reset          in   synchronous, active-high
//   i_start        in   pulse: clear all state, latch configuration
//   i_row_num      in   number of active rows (latched on i_start)
//   i_channel_num  in   channels per sum, 0 behaves as 1 (latched on i_start)
//   bus            --   pe_cluster_psum_acc_if.master: row inputs + output stream
//   o_busy         out  accumulation, pending result or FIFO entry in flight
//   o_overflow     out  sticky: a completed result was dropped
// ---------------------------------------------------------------------------
module pe_cluster_psum_acc #(
  parameter int DATA_WIDTH   = 16,
  parameter int MAX_ROW_NUM  = 16,
  parameter int MAX_CHANNELS = 8,
  parameter int FIFO_DEPTH   = 8,
  localparam int LOG_MRN     = $clog2(MAX_ROW_NUM),
  localparam int LOG_MCH     = $clog2(MAX_CHANNELS)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         i_start,
  input  logic [LOG_MRN:0]             i_row_num,
  input  logic [LOG_MCH:0]             i_channel_num,
  pe_cluster_psum_acc_if.master        bus,
  output logic                         o_busy,
  output logic                         o_overflow
);

  localparam int LOG_FD = $clog2(FIFO_DEPTH);
  localparam int CW     = LOG_MCH + 1;

  // Saturation limits of the signed psum.
  localparam logic [DATA_WIDTH-1:0] SAT_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic [DATA_WIDTH-1:0] SAT_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  // -------------------------------------------------------------------------
  // Configuration registers
  // -------------------------------------------------------------------------
  logic [LOG_MRN:0] row_num_q;
  logic [CW-1:0]    chan_num_q;

  // -------------------------------------------------------------------------
  // Per-row state
  // -------------------------------------------------------------------------
  logic [MAX_ROW_NUM-1:0][DATA_WIDTH-1:0] acc;
  logic [MAX_ROW_NUM-1:0][CW-1:0]         cnt;
  logic [MAX_ROW_NUM-1:0][DATA_WIDTH-1:0] hold;
  logic [MAX_ROW_NUM-1:0]                 pend;

  // -------------------------------------------------------------------------
  // Per-row combinational terms
  // -------------------------------------------------------------------------
  logic [MAX_ROW_NUM-1:0]                 row_en;
  logic [MAX_ROW_NUM-1:0]                 hit;
  logic [MAX_ROW_NUM-1:0]                 complete;
  logic [MAX_ROW_NUM-1:0]                 push_clear;
  logic [MAX_ROW_NUM-1:0]                 drop;
  logic [MAX_ROW_NUM-1:0][DATA_WIDTH-1:0] sum;
  logic                                   cnt_active;

  // -------------------------------------------------------------------------
  // Arbiter and FIFO
  // -------------------------------------------------------------------------
  logic                  grant_valid;
  logic [LOG_MRN-1:0]    grant_idx;
  logic                  push;
  logic                  pop;
  logic                  fifo_full;
  logic                  fifo_nonempty;
  logic [DATA_WIDTH-1:0] fifo_data [FIFO_DEPTH];
  logic [LOG_MRN-1:0]    fifo_row  [FIFO_DEPTH];
  logic [LOG_FD-1:0]     wr_ptr;
  logic [LOG_FD-1:0]     rd_ptr;
  logic [LOG_FD:0]       count;

  // Signed add with clamping: overflow shows up as disagreement between the
  // sign-extended carry bit and the result sign bit.
  function automatic logic [DATA_WIDTH-1:0] sat_add(
    input logic [DATA_WIDTH-1:0] a,
    input logic [DATA_WIDTH-1:0] b
  );
    logic [DATA_WIDTH:0] s;
    s = {a[DATA_WIDTH-1], a} + {b[DATA_WIDTH-1], b};
    if (s[DATA_WIDTH] != s[DATA_WIDTH-1]) begin
      sat_add = s[DATA_WIDTH] ? SAT_MIN : SAT_MAX;
    end else begin
      sat_add = s[DATA_WIDTH-1:0];
    end
  endfunction

  // Configuration: rows stay disabled and each sum is one channel wide until
  // the first i_start. A channel count of zero is stored as one so the
  // completion compare never has to special-case it.
  always_ff @(posedge clk) begin
    if (reset) begin
      row_num_q  <= '0;
      chan_num_q <= CW'(1);
    end else if (i_start) begin
      row_num_q  <= i_row_num;
      chan_num_q <= (i_channel_num == '0) ? CW'(1) : i_channel_num;
    end
  end

  // Per-row decode. Pulses are ignored on disabled rows and in the i_start
  // cycle, since that cycle wipes all accumulation state anyway.
  always_comb begin
    row_en     = '0;
    hit        = '0;
    complete   = '0;
    sum        = '0;
    cnt_active = 1'b0;
    for (int r = 0; r < MAX_ROW_NUM; r++) begin
      row_en[r]   = (r < int'(row_num_q));
      hit[r]      = bus.i_peout_valid[r] && row_en[r] && !i_start;
      sum[r]      = sat_add(acc[r], bus.i_peout_data[r]);
      complete[r] = hit[r] && ((cnt[r] + CW'(1)) == chan_num_q);
      if (cnt[r] != '0) begin
        cnt_active = 1'b1;
      end
    end
  end

  // Fixed-priority arbiter: scanning from the top down lets the lowest
  // pending index overwrite any higher one.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    for (int r = MAX_ROW_NUM - 1; r >= 0; r--) begin
      if (pend[r]) begin
        grant_valid = 1'b1;
        grant_idx   = LOG_MRN'(r);
      end
    end
  end

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign fifo_nonempty = (count != '0);
  assign fifo_full     = (count == (LOG_FD + 1)'(FIFO_DEPTH));
  assign pop           = fifo_nonempty && bus.i_ready;
  assign push          = grant_valid && (!fifo_full || pop) && !i_start;

  // Which row the push releases, and which completions find their holding
  // register still occupied. A row whose result is being pushed this cycle
  // frees its holding register in time for a new completion.
  always_comb begin
    push_clear = '0;
    drop       = '0;
    for (int r = 0; r < MAX_ROW_NUM; r++) begin
      push_clear[r] = push && (grant_idx == LOG_MRN'(r));
      drop[r]       = complete[r] && pend[r] && !push_clear[r];
    end
  end

  // Accumulate, complete and hand results to the holding registers. A
  // completion clears acc/cnt even when its result is dropped, so the row
  // starts a fresh sum either way.
  always_ff @(posedge clk) begin
    if (reset || i_start) begin
      acc  <= '0;
      cnt  <= '0;
      hold <= '0;
      pend <= '0;
    end else begin
      for (int r = 0; r < MAX_ROW_NUM; r++) begin
        if (complete[r]) begin
          acc[r] <= '0;
          cnt[r] <= '0;
          if (!drop[r]) begin
            hold[r] <= sum[r];
            pend[r] <= 1'b1;
          end
        end else begin
          if (hit[r]) begin
            acc[r] <= sum[r];
            cnt[r] <= cnt[r] + CW'(1);
          end
          if (push_clear[r]) begin
            pend[r] <= 1'b0;
          end
        end
      end
    end
  end

  // Sticky overflow flag, cleared only by reset or a new run.
  always_ff @(posedge clk) begin
    if (reset || i_start) begin
      o_overflow <= 1'b0;
    end else if (|drop) begin
      o_overflow <= 1'b1;
    end
  end

  // FIFO storage carries no reset; the pointers and count decide which
  // entries are meaningful.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data[wr_ptr] <= hold[grant_idx];
      fifo_row[wr_ptr]  <= grant_idx;
    end
  end

  // FIFO pointers and occupancy. Depth is a power of two, so pointers wrap
  // naturally.
  always_ff @(posedge clk) begin
    if (reset || i_start) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + LOG_FD'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + LOG_FD'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + (LOG_FD + 1)'(1);
        2'b01:   count <= count - (LOG_FD + 1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Head of the FIFO is presented directly; outputs read as zero when empty
  // so nothing stale is visible after reset or i_start.
  assign bus.o_valid   = fifo_nonempty;
  assign bus.o_data    = fifo_nonempty ? fifo_data[rd_ptr] : '0;
  assign bus.o_row_idx = fifo_nonempty ? fifo_row[rd_ptr] : '0;

  assign o_busy = (|pend) || fifo_nonempty || cnt_active;

endmodule

// File: tb/tb_pe_cluster_psum_acc.sv
// ---------------------------------------------------------------------------
// tb_pe_cluster_psum_acc
//
// Directed bench for pe_cluster_psum_acc. Expected outputs are queued when the
// completing stimulus is driven and compared when the DUT hands an entry over
// the valid/ready handshake.
// ---------------------------------------------------------------------------
module tb_pe_cluster_psum_acc;

  localparam int DW  = 16;
  localparam int MRN = 16;

  typedef struct {
    logic [DW-1:0] data;
    logic [3:0]    row;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       i_start;
  logic [4:0] i_row_num;
  logic [3:0] i_channel_num;
  logic       o_busy;
  logic       o_overflow;

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t sb[$];
  exp_t mon_e;

  pe_cluster_psum_acc_if #(.DATA_WIDTH(DW), .MAX_ROW_NUM(MRN)) bus ();

  pe_cluster_psum_acc #(
    .DATA_WIDTH(DW),
    .MAX_ROW_NUM(MRN),
    .MAX_CHANNELS(8),
    .FIFO_DEPTH(8)
  ) dut (
    .clk(clk),
    .reset(reset),
    .i_start(i_start),
    .i_row_num(i_row_num),
    .i_channel_num(i_channel_num),
    .bus(bus.master),
    .o_busy(o_busy),
    .o_overflow(o_overflow)
  );

  always #5 clk = ~clk;

  // Comparison point: counts every evaluation and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    n_checks++;
    assert (observed === expected)
    else begin
      n_fail++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one cycle of row pulses, then drop the valids.
  task automatic applyStimulus(input logic [MRN-1:0] mask,
                               input logic [MRN-1:0][DW-1:0] vals);
    bus.i_peout_valid = mask;
    bus.i_peout_data  = vals;
    tick();
    bus.i_peout_valid = '0;
  endtask

  task automatic pulse_row(input int r, input logic [DW-1:0] v);
    logic [MRN-1:0]         m;
    logic [MRN-1:0][DW-1:0] d;
    m    = '0;
    d    = '0;
    m[r] = 1'b1;
    d[r] = v;
    applyStimulus(m, d);
  endtask

  task automatic do_start(input logic [4:0] rows, input logic [3:0] chans);
    i_start       = 1'b1;
    i_row_num     = rows;
    i_channel_num = chans;
    tick();
    i_start = 1'b0;
  endtask

  task automatic expect_out(input logic [DW-1:0] d, input logic [3:0] r);
    exp_t e;
    e.data = d;
    e.row  = r;
    sb.push_back(e);
  endtask

  // Bounded wait until every queued result has come out.
  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while ((sb.size() != 0 || bus.o_valid) && n < budget) begin
      tick();
      n++;
    end
    checkOutput("drain_sb_empty", 32'(sb.size()), 32'd0);
    checkOutput("drain_o_valid", 32'(bus.o_valid), 32'd0);
  endtask

  // Output monitor: every accepted entry is compared against the queue head.
  always @(negedge clk) begin
    if (!reset && bus.o_valid && bus.i_ready) begin
      if (sb.size() == 0) begin
        checkOutput("unexpected_out_valid", 32'(bus.o_valid), 32'd0);
      end else begin
        mon_e = sb.pop_front();
        checkOutput("sb_data", 32'(bus.o_data), 32'(mon_e.data));
        checkOutput("sb_row", 32'(bus.o_row_idx), 32'(mon_e.row));
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired observed=running required=finished");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [MRN-1:0][DW-1:0] vals;

    reset             = 1'b1;
    i_start           = 1'b0;
    i_row_num         = '0;
    i_channel_num     = '0;
    bus.i_ready       = 1'b0;
    bus.i_peout_valid = '0;
    bus.i_peout_data  = '0;
    repeat (3) tick();
    reset = 1'b0;

    // Reset state
    checkOutput("rst_o_valid", 32'(bus.o_valid), 32'd0);
    checkOutput("rst_o_data", 32'(bus.o_data), 32'd0);
    checkOutput("rst_o_row_idx", 32'(bus.o_row_idx), 32'd0);
    checkOutput("rst_o_busy", 32'(o_busy), 32'd0);
    checkOutput("rst_o_overflow", 32'(o_overflow), 32'd0);

    // All rows disabled before the first i_start
    bus.i_ready = 1'b1;
    pulse_row(0, 16'd77);
    tick();
    checkOutput("pre_start_busy", 32'(o_busy), 32'd0);
    checkOutput("pre_start_valid", 32'(bus.o_valid), 32'd0);

    // Three-channel sum on row 0 with latency check
    $display("[TB] three-channel accumulation");
    do_start(5'd1, 4'd3);
    expect_out(16'd13, 4'd0);
    pulse_row(0, 16'd5);
    pulse_row(0, 16'hFFFE);
    pulse_row(0, 16'd10);
    checkOutput("lat_cycle1_valid", 32'(bus.o_valid), 32'd0);
    checkOutput("lat_cycle1_busy", 32'(o_busy), 32'd1);
    tick();
    checkOutput("lat_cycle2_valid", 32'(bus.o_valid), 32'd1);
    checkOutput("lat_cycle2_data", 32'(bus.o_data), 32'd13);
    tick();
    checkOutput("after_pop_valid", 32'(bus.o_valid), 32'd0);
    checkOutput("after_pop_busy", 32'(o_busy), 32'd0);

    // Same-cycle completions leave in row order; disabled row 5 ignored
    $display("[TB] simultaneous completions");
    do_start(5'd4, 4'd1);
    expect_out(16'd9, 4'd0);
    expect_out(16'd8, 4'd1);
    expect_out(16'd7, 4'd3);
    vals    = '0;
    vals[3] = 16'd7;
    vals[1] = 16'd8;
    vals[0] = 16'd9;
    vals[5] = 16'd55;
    applyStimulus(16'b0000_0000_0010_1011, vals);
    tick();
    checkOutput("arb_c2_data", 32'(bus.o_data), 32'd9);
    tick();
    checkOutput("arb_c3_row", 32'(bus.o_row_idx), 32'd1);
    tick();
    checkOutput("arb_c4_row", 32'(bus.o_row_idx), 32'd3);
    tick();
    checkOutput("arb_c5_valid", 32'(bus.o_valid), 32'd0);
    wait_drain(10);

    // Saturation in both directions
    $display("[TB] saturation");
    do_start(5'd1, 4'd2);
    expect_out(16'h7FFF, 4'd0);
    pulse_row(0, 16'd30000);
    pulse_row(0, 16'd30000);
    wait_drain(10);
    expect_out(16'h8000, 4'd0);
    pulse_row(0, 16'(-30000));
    pulse_row(0, 16'(-30000));
    wait_drain(10);

    // Channel count 0 behaves as 1; pulse in the i_start cycle is ignored
    $display("[TB] channel zero and start-cycle pulse");
    bus.i_peout_valid   = 16'h0001;
    bus.i_peout_data[0] = 16'd500;
    do_start(5'd1, 4'd0);
    bus.i_peout_valid = '0;
    expect_out(16'd42, 4'd0);
    pulse_row(0, 16'd42);
    wait_drain(10);

    // Fill the FIFO with ready low, then overflow row 8
    $display("[TB] FIFO full, pending rows and overflow");
    bus.i_ready = 1'b0;
    do_start(5'd16, 4'd1);
    for (int r = 0; r < MRN; r++) begin
      expect_out(16'(100 + r), 4'(r));
      pulse_row(r, 16'(100 + r));
      repeat (9) tick();
    end
    checkOutput("full_overflow_before", 32'(o_overflow), 32'd0);
    checkOutput("full_head_data", 32'(bus.o_data), 32'd100);
    checkOutput("full_busy", 32'(o_busy), 32'd1);
    pulse_row(8, 16'd999);
    tick();
    checkOutput("full_overflow_after", 32'(o_overflow), 32'd1);
    checkOutput("full_head_row", 32'(bus.o_row_idx), 32'd0);

    // One pop while full with pending rows: head advances, row 8 enters
    bus.i_ready = 1'b1;
    tick();
    bus.i_ready = 1'b0;
    checkOutput("pop_push_head", 32'(bus.o_data), 32'd101);
    repeat (3) tick();
    checkOutput("stall_stable_data", 32'(bus.o_data), 32'd101);
    checkOutput("stall_stable_row", 32'(bus.o_row_idx), 32'd1);
    bus.i_ready = 1'b1;
    wait_drain(60);
    checkOutput("overflow_sticky", 32'(o_overflow), 32'd1);
    checkOutput("drained_busy", 32'(o_busy), 32'd0);

    // i_start mid-accumulation with a full FIFO and overflow set
    $display("[TB] restart mid-operation");
    bus.i_ready = 1'b0;
    do_start(5'd16, 4'd2);
    for (int r = 0; r < MRN; r++) vals[r] = 16'(r + 1);
    applyStimulus('1, vals);
    applyStimulus('1, vals);
    repeat (10) tick();
    pulse_row(15, 16'd1);
    pulse_row(15, 16'd1);
    pulse_row(0, 16'd1);
    tick();
    checkOutput("pre_restart_overflow", 32'(o_overflow), 32'd1);
    checkOutput("pre_restart_valid", 32'(bus.o_valid), 32'd1);
    do_start(5'd1, 4'd3);
    checkOutput("restart_valid", 32'(bus.o_valid), 32'd0);
    checkOutput("restart_busy", 32'(o_busy), 32'd0);
    checkOutput("restart_overflow", 32'(o_overflow), 32'd0);
    bus.i_ready = 1'b1;
    expect_out(16'd6, 4'd0);
    pulse_row(0, 16'd1);
    pulse_row(0, 16'd2);
    pulse_row(0, 16'd3);
    wait_drain(10);

    // Reset mid-accumulation discards state and disables rows again
    $display("[TB] reset mid-operation");
    do_start(5'd1, 4'd2);
    pulse_row(0, 16'd4);
    checkOutput("pre_reset_busy", 32'(o_busy), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checkOutput("post_reset_busy", 32'(o_busy), 32'd0);
    pulse_row(0, 16'd4);
    tick();
    checkOutput("post_reset_disabled", 32'(o_busy), 32'd0);
    wait_drain(5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
